dds_sweep_ctrl: RTL and testbench

- Frequency-sweep sequencer that drives the frequency control word (fcw) and phase offset inputs of the 16-bit pipelined CORDIC DDS.
- Steps fcw from a start value to a stop value in programmable increments, holding each value for a programmable number of clocks (dwell).
- Supports single, sawtooth, triangle and hold modes.
- Sits directly upstream of the DDS; fcw/offset connect straight to its fcw/offset inputs.

---
 rtl/dds_sweep_pkg.sv | 21 ++
 rtl/dds_dwell_timer.sv | 39 +++
 rtl/dds_sweep_ctrl.sv | 158 +++++++++++++++
 tb/tb_dds_sweep_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/dds_sweep_pkg.sv
// Shared definitions for the DDS frequency-sweep controller.
//   state_t      : sequencer states (IDLE / RUN / HOLD)
//   MODE_*       : encodings of the 2-bit mode input
//   FW_DEF/DW_DEF: default widths of frequency words and dwell counts
package dds_sweep_pkg;

  localparam int FW_DEF = 16;
  localparam int DW_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [1:0] MODE_SINGLE = 2'd0;
  localparam logic [1:0] MODE_SAW    = 2'd1;
  localparam logic [1:0] MODE_TRI    = 2'd2;
  localparam logic [1:0] MODE_HOLD   = 2'd3;

endpackage

// File: rtl/dds_dwell_timer.sv
// Dwell timer: DW-bit down counter that measures how long the current fcw
// value has been presented.
//   clk, reset : clock, asynchronous active-low reset
//   en         : count down (sweep is running)
//   load       : reload the counter with load_val (takes priority over en)
//   load_val   : dwell length in cycles, must be >= 1
//   expire     : high during the last cycle of the dwell period
module dds_dwell_timer
  import dds_sweep_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          load,
  input  logic [DW-1:0] load_val,
  output logic          expire
);

  logic [DW-1:0] count;

  // NOTE: registers are written with non-blocking assignments so every
  // flop samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && count != '0) begin
      count <= count - 1'b1;
    end
  end

  // Counter holds D during the first presented cycle, so reaching 1 marks
  // the D-th (last) cycle of the dwell.
  assign expire = en && (count == DW'(1));

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer feeding the fcw/offset inputs of the CORDIC DDS.
// Steps fcw from fcw_start toward fcw_stop by fcw_step, holding each value
// for max(dwell,1) cycles, in single, sawtooth, triangle or hold mode.
//   clk, reset        : clock, asynchronous active-low reset
//   start, abort      : begin a sweep (IDLE only) / return to IDLE (wins)
//   mode              : 0 single, 1 sawtooth, 2 triangle, 3 hold
//   fcw_start/stop    : sweep endpoints
//   fcw_step          : unsigned step magnitude (0 forces HOLD)
//   dwell             : cycles per fcw value (0 treated as 1)
//   offset_in         : phase offset, latched at start
//   fcw, offset       : registered words to the DDS
//   fcw_update        : pulse in the first cycle of each new fcw value
//   busy              : high in RUN/HOLD
//   done              : pulse when a single sweep completes
module dds_sweep_ctrl
  import dds_sweep_pkg::*;
#(
  parameter int FW = FW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic [1:0]    mode,
  input  logic [FW-1:0] fcw_start,
  input  logic [FW-1:0] fcw_stop,
  input  logic [FW-1:0] fcw_step,
  input  logic [DW-1:0] dwell,
  input  logic [FW-1:0] offset_in,
  output logic [FW-1:0] fcw,
  output logic [FW-1:0] offset,
  output logic          fcw_update,
  output logic          busy,
  output logic          done
);

  state_t        state;
  logic [1:0]    mode_r;
  logic [FW-1:0] start_r, stop_r, step_r;
  logic [DW-1:0] dwell_r;
  logic          up0_r;     // initial direction: stop >= start
  logic          dir_up_r;  // current direction; toggles at triangle endpoints

  logic          start_ok;
  logic [DW-1:0] dwell_eff;
  logic          tmr_load, tmr_expire;
  logic [FW-1:0] target, rev_target, step_fwd, step_rev;

  // One step at FW+1 bits; any carry/borrow or overshoot of the endpoint
  // clamps to the endpoint so fcw never wraps.
  function automatic logic [FW-1:0] next_fcw(input logic [FW-1:0] cur,
                                             input logic [FW-1:0] step,
                                             input logic [FW-1:0] tgt,
                                             input logic          up);
    logic [FW:0] sum;
    sum = up ? ({1'b0, cur} + {1'b0, step}) : ({1'b0, cur} - {1'b0, step});
    if (up) next_fcw = (sum[FW] || sum[FW-1:0] >= tgt) ? tgt : sum[FW-1:0];
    else    next_fcw = (sum[FW] || sum[FW-1:0] <= tgt) ? tgt : sum[FW-1:0];
  endfunction

  assign start_ok  = (state == IDLE) && start && !abort;
  assign dwell_eff = (dwell == '0) ? DW'(1) : dwell;

  // Heading the initial way means aiming at stop; reversed means at start.
  assign target     = (dir_up_r == up0_r) ? stop_r  : start_r;
  assign rev_target = (dir_up_r == up0_r) ? start_r : stop_r;
  assign step_fwd   = next_fcw(fcw, step_r, target, dir_up_r);
  assign step_rev   = next_fcw(fcw, step_r, rev_target, ~dir_up_r);

  // Reload on every fcw change so each value is held exactly D cycles.
  assign tmr_load = start_ok || ((state == RUN) && tmr_expire && !abort);

  dds_dwell_timer #(.DW(DW)) u_dwell (
    .clk      (clk),
    .reset    (reset),
    .en       (state == RUN),
    .load     (tmr_load),
    .load_val ((state == IDLE) ? dwell_eff : dwell_r),
    .expire   (tmr_expire)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      mode_r     <= '0;
      start_r    <= '0;
      stop_r     <= '0;
      step_r     <= '0;
      dwell_r    <= '0;
      up0_r      <= 1'b0;
      dir_up_r   <= 1'b0;
      fcw        <= '0;
      offset     <= '0;
      fcw_update <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      fcw_update <= 1'b0;
      done       <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ok) begin
            mode_r     <= mode;
            start_r    <= fcw_start;
            stop_r     <= fcw_stop;
            step_r     <= fcw_step;
            dwell_r    <= dwell_eff;
            up0_r      <= (fcw_stop >= fcw_start);
            dir_up_r   <= (fcw_stop >= fcw_start);
            fcw        <= fcw_start;
            offset     <= offset_in;
            fcw_update <= 1'b1;
            busy       <= 1'b1;
            state      <= (mode == MODE_HOLD || fcw_step == '0) ? HOLD : RUN;
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (tmr_expire) begin
            if (fcw == target) begin
              case (mode_r)
                MODE_SINGLE: begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                end
                MODE_TRI: begin
                  // Step away immediately so the endpoint is held only once.
                  dir_up_r   <= ~dir_up_r;
                  fcw        <= step_rev;
                  fcw_update <= 1'b1;
                end
                default: begin
                  fcw        <= start_r;
                  fcw_update <= 1'b1;
                end
              endcase
            end else begin
              fcw        <= step_fwd;
              fcw_update <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Scoreboard bench for dds_sweep_ctrl: scenarios push expected fcw_update /
// done events (value and cycle) before starting; a monitor pops and compares
// each event the DUT presents.
module tb_dds_sweep_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [15:0] fcw_start = '0, fcw_stop = '0, fcw_step = '0, offset_in = '0;
  logic [15:0] dwell = '0;
  logic [15:0] fcw, offset;
  logic        fcw_update, busy, done;

  dds_sweep_ctrl #(.FW(16), .DW(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .mode       (mode),
    .fcw_start  (fcw_start),
    .fcw_stop   (fcw_stop),
    .fcw_step   (fcw_step),
    .dwell      (dwell),
    .offset_in  (offset_in),
    .fcw        (fcw),
    .offset     (offset),
    .fcw_update (fcw_update),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_done;
    logic [15:0] val;
    int          at;
  } evt_t;
  evt_t exp_q[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input bit is_done, input logic [15:0] val, input int at);
    evt_t e;
    e.is_done = is_done;
    e.val     = val;
    e.at      = at;
    exp_q.push_back(e);
  endtask

  // Monitor: every fcw_update or done pulse must match the next expectation.
  always @(negedge clk) begin
    if (reset && (fcw_update || done)) begin
      check("evt_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin : pop_blk
        evt_t e;
        e = exp_q.pop_front();
        check("evt_done", 32'(done), 32'(e.is_done));
        check("evt_fcw", 32'(fcw), 32'(e.val));
        check("evt_cycle", 32'(cyc), 32'(e.at));
        check("evt_excl", 32'(fcw_update & done), 32'd0);
      end
    end
  end

  // Called at a negedge; the following posedge samples start.
  task automatic do_start(input logic [1:0] m, input logic [15:0] s, input logic [15:0] p,
                          input logic [15:0] st, input logic [15:0] d, input logic [15:0] off);
    mode = m; fcw_start = s; fcw_stop = p; fcw_step = st; dwell = d; offset_in = off;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  int base;

  initial begin
    // Reset state
    #1 reset = 1'b0;
    #2;
    check("rst_fcw", 32'(fcw), 32'd0);
    check("rst_offset", 32'(offset), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_upd", 32'(fcw_update), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Single up sweep: 100,110,120,130 x3 cycles, done at 13
    base = cyc;
    push(0, 16'd100, base + 1); push(0, 16'd110, base + 4);
    push(0, 16'd120, base + 7); push(0, 16'd130, base + 10);
    push(1, 16'd130, base + 13);
    do_start(2'd0, 16'd100, 16'd130, 16'd10, 16'd3, 16'h0000);
    check("s1_busy_k1", 32'(busy), 32'd1);
    check("s1_fcw_k1", 32'(fcw), 32'd100);
    wait_to(base + 12);
    check("s1_busy_k12", 32'(busy), 32'd1);
    wait_to(base + 13);
    check("s1_busy_k13", 32'(busy), 32'd0);
    wait_to(base + 16);
    check("s1_fcw_hold", 32'(fcw), 32'd130);
    check("s1_drain", 32'(exp_q.size()), 32'd0);

    // Clamp at top of range, dwell 0 -> 1
    base = cyc;
    push(0, 16'hFFF0, base + 1); push(0, 16'hFFFF, base + 2);
    push(1, 16'hFFFF, base + 3);
    do_start(2'd0, 16'hFFF0, 16'hFFFF, 16'h0020, 16'd0, 16'h0000);
    wait_to(base + 3);
    check("s2_busy", 32'(busy), 32'd0);
    wait_to(base + 6);
    check("s2_fcw_nowrap", 32'(fcw), 32'hFFFF);
    check("s2_drain", 32'(exp_q.size()), 32'd0);

    // Triangle starting downward
    base = cyc;
    push(0, 16'd50, base + 1); push(0, 16'd35, base + 2); push(0, 16'd20, base + 3);
    push(0, 16'd35, base + 4); push(0, 16'd50, base + 5); push(0, 16'd35, base + 6);
    push(0, 16'd20, base + 7);
    do_start(2'd2, 16'd50, 16'd20, 16'd15, 16'd1, 16'h0000);
    wait_to(base + 6);
    check("s3_busy", 32'(busy), 32'd1);
    wait_to(base + 7);
    pulse_abort();
    check("s3_abort_busy", 32'(busy), 32'd0);
    check("s3_abort_fcw", 32'(fcw), 32'd20);
    wait_to(base + 10);
    check("s3_drain", 32'(exp_q.size()), 32'd0);

    // Sawtooth 0,3,6,8 reload 0
    base = cyc;
    push(0, 16'd0, base + 1); push(0, 16'd3, base + 3); push(0, 16'd6, base + 5);
    push(0, 16'd8, base + 7); push(0, 16'd0, base + 9); push(0, 16'd3, base + 11);
    do_start(2'd1, 16'd0, 16'd8, 16'd3, 16'd2, 16'h0000);
    wait_to(base + 12);
    pulse_abort();
    check("s4_abort_busy", 32'(busy), 32'd0);
    check("s4_abort_fcw", 32'(fcw), 32'd3);
    wait_to(base + 15);
    check("s4_drain", 32'(exp_q.size()), 32'd0);

    // Start while busy ignored; abort at 110; start+abort in IDLE dropped
    base = cyc;
    push(0, 16'd100, base + 1); push(0, 16'd110, base + 4);
    do_start(2'd0, 16'd100, 16'd130, 16'd10, 16'd3, 16'h0000);
    wait_to(base + 5);
    fcw_start = 16'd7; fcw_stop = 16'd500; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("s5_fcw_k6", 32'(fcw), 32'd110);
    check("s5_busy_k6", 32'(busy), 32'd1);
    pulse_abort();
    check("s5_abort_busy", 32'(busy), 32'd0);
    check("s5_abort_fcw", 32'(fcw), 32'd110);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("s5_both_busy", 32'(busy), 32'd0);
    check("s5_both_fcw", 32'(fcw), 32'd110);
    repeat (3) @(negedge clk);
    check("s5_idle_busy", 32'(busy), 32'd0);
    check("s5_drain", 32'(exp_q.size()), 32'd0);

    // Hold mode, then asynchronous reset mid-cycle
    base = cyc;
    push(0, 16'h1234, base + 1);
    do_start(2'd3, 16'h1234, 16'h2000, 16'd5, 16'd2, 16'h4000);
    check("s6_offset", 32'(offset), 32'h4000);
    check("s6_busy_k1", 32'(busy), 32'd1);
    wait_to(base + 25);
    check("s6_fcw", 32'(fcw), 32'h1234);
    check("s6_busy_k25", 32'(busy), 32'd1);
    check("s6_drain", 32'(exp_q.size()), 32'd0);
    #2 reset = 1'b0;
    #1;
    check("s6_rst_fcw", 32'(fcw), 32'd0);
    check("s6_rst_offset", 32'(offset), 32'd0);
    check("s6_rst_busy", 32'(busy), 32'd0);
    check("s6_rst_done", 32'(done), 32'd0);
    check("s6_rst_upd", 32'(fcw_update), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check("s6_post_busy", 32'(busy), 32'd0);

    // Step 0 in single mode enters HOLD
    base = cyc;
    push(0, 16'd77, base + 1);
    do_start(2'd0, 16'd77, 16'd200, 16'd0, 16'd1, 16'h0000);
    wait_to(base + 30);
    check("s7_busy", 32'(busy), 32'd1);
    check("s7_fcw", 32'(fcw), 32'd77);
    pulse_abort();
    check("s7_abort_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    check("s7_drain", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
